apb_rr_master: RTL and testbench

- Two-requester APB master that shares one APB memory slave between two on-chip clients.
- Arbitrates requests round-robin and latches the winning command.
- Drives the APB SETUP/ACCESS phases, then waits for P_ready, bounded by a timeout.
- Returns read data and error status to the granted requester with a one-cycle done pulse.

---
 rtl/apb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 32 +++
 rtl/apb_rr_master.sv | 184 ++++++++++++++++++
 tb/tb_apb_rr_master.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared encodings for the two-requester APB master: FSM states and requester indices.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last-served index only moves when the owner commits it.
module rr_arb2
  import apb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_en_i,
  input  logic upd_idx_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (upd_en_i) last_d = upd_idx_i;
  end

  // Reset to REQ1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_q <= REQ1;
    else          last_q <= last_d;
  end

  assign gnt_valid_o = req0_i | req1_i;
  assign gnt_idx_o   = (req0_i && req1_i) ? ~last_q : (req1_i ? REQ1 : REQ0);

endmodule

// File: rtl/apb_rr_master.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, ACCESS timeout,
// registered per-requester accept/done/rdata/err.
//   state  | meaning
//   IDLE   | P_sel=0, arbitrate pending requests
//   SETUP  | P_sel=1, P_enable=0, one cycle
//   ACCESS | P_sel=1, P_enable=1, wait for P_ready or timeout
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int ADDR_width = 4,
  parameter int DATA_width = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  P_clk,
  input  logic                  P_reset_n,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_width-1:0] req0_addr,
  input  logic [DATA_width-1:0] req0_wdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_width-1:0] req1_addr,
  input  logic [DATA_width-1:0] req1_wdata,
  output logic                  req0_accept,
  output logic                  req0_done,
  output logic [DATA_width-1:0] req0_rdata,
  output logic                  req0_err,
  output logic                  req1_accept,
  output logic                  req1_done,
  output logic [DATA_width-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  P_sel,
  output logic                  P_enable,
  output logic                  P_write,
  output logic [ADDR_width-1:0] P_addr,
  output logic [DATA_width-1:0] P_wdata,
  input  logic [DATA_width-1:0] P_rdata,
  input  logic                  P_ready,
  input  logic                  P_slverr
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  grant_q, grant_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_width-1:0] paddr_q, paddr_d;
  logic [DATA_width-1:0] pwdata_q, pwdata_d;
  logic                  acc0_q, acc0_d, acc1_q, acc1_d, done0_q, done0_d, done1_q, done1_d;
  logic [DATA_width-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic                  arb_valid, arb_idx, upd_en;
  logic [DATA_width-1:0] rsp_rdata;
  logic                  rsp_err;

  rr_arb2 u_arb (
    .clk_i      (P_clk),
    .rst_n_i    (P_reset_n),
    .req0_i     (req0_valid),
    .req1_i     (req1_valid),
    .upd_en_i   (upd_en),
    .upd_idx_i  (grant_q),
    .gnt_valid_o(arb_valid),
    .gnt_idx_o  (arb_idx)
  );

  // A timed-out transfer reports err=1 with zero data; writes always return zero data.
  assign rsp_rdata = (P_ready && !pwrite_q) ? P_rdata : '0;
  assign rsp_err   = P_ready ? P_slverr : 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    acc0_d    = 1'b0;
    acc1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    upd_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d  = arb_idx;
          pwrite_d = (arb_idx == REQ1) ? req1_write : req0_write;
          paddr_d  = (arb_idx == REQ1) ? req1_addr  : req0_addr;
          pwdata_d = (arb_idx == REQ1) ? req1_wdata : req0_wdata;
          psel_d   = 1'b1;
          acc0_d   = (arb_idx == REQ0);
          acc1_d   = (arb_idx == REQ1);
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (P_ready || (cnt_q == CNT_LAST)) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          upd_en    = 1'b1;
          state_d   = ST_IDLE;
          if (grant_q == REQ1) begin
            done1_d  = 1'b1;
            rdata1_d = rsp_rdata;
            err1_d   = rsp_err;
          end else begin
            done0_d  = 1'b1;
            rdata0_d = rsp_rdata;
            err0_d   = rsp_err;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      grant_q   <= REQ0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      acc0_q    <= 1'b0;
      acc1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      acc0_q    <= acc0_d;
      acc1_q    <= acc1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign req0_accept = acc0_q;
  assign req1_accept = acc1_q;
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign req0_err    = err0_q;
  assign req1_err    = err1_q;
  assign P_sel       = psel_q;
  assign P_enable    = penable_q;
  assign P_write     = pwrite_q;
  assign P_addr      = paddr_q;
  assign P_wdata     = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: wait-state APB memory slave plus a transaction-level model
// (memory image, last-served requester, expected latency/err/rdata per transfer).
module tb_apb_rr_master;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          P_clk = 1'b0;
  logic          P_reset_n = 1'b1;
  logic          req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          req0_accept, req0_done, req0_err, req1_accept, req1_done, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          P_sel, P_enable, P_write, P_ready, P_slverr;
  logic [AW-1:0] P_addr;
  logic [DW-1:0] P_wdata, P_rdata;

  int checks = 0;
  int errors = 0;

  always #5 P_clk = ~P_clk;

  apb_rr_master #(.ADDR_width(AW), .DATA_width(DW), .TIMEOUT(TMO)) dut (
    .P_clk(P_clk), .P_reset_n(P_reset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_accept(req0_accept), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_accept(req1_accept), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .P_sel(P_sel), .P_enable(P_enable), .P_write(P_write), .P_addr(P_addr), .P_wdata(P_wdata),
    .P_rdata(P_rdata), .P_ready(P_ready), .P_slverr(P_slverr)
  );

  // APB memory slave: ready after slave_wait ACCESS cycles, optional slave error
  logic [DW-1:0] slv_mem [16];
  int wait_cnt = 0;
  int slave_wait = 0;
  logic slave_err = 1'b0;

  assign P_ready  = P_sel && P_enable && (wait_cnt >= slave_wait);
  assign P_rdata  = slv_mem[P_addr];
  assign P_slverr = slave_err;

  always @(posedge P_clk) begin
    if (P_sel && P_enable && !P_ready) wait_cnt <= wait_cnt + 1;
    else                               wait_cnt <= 0;
    if (P_sel && P_enable && P_ready && P_write && !P_slverr) slv_mem[P_addr] <= P_wdata;
  end

  // reference model state
  logic [DW-1:0] ref_mem [16];
  logic model_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input logic v, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (idx == 0) begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_psel"},    32'(P_sel), 0);
    chk({tag, "_penable"}, 32'(P_enable), 0);
    chk({tag, "_accept"},  32'({req0_accept, req1_accept}), 0);
    chk({tag, "_done"},    32'({req0_done, req1_done}), 0);
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    P_reset_n = 1'b0;
    repeat (2) @(negedge P_clk);
    chk_quiet("rst");
    chk("rst_outs", 32'({P_write, P_addr, P_wdata, req0_rdata, req1_rdata, req0_err, req1_err}), 0);
    P_reset_n = 1'b1;
    model_last = 1'b1;
    @(negedge P_clk);
  endtask

  // single transfer from one requester; called on a negedge with the DUT idle
  task automatic xfer(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int w, input logic se);
    int acc_cyc = 0, setup_cyc = 0;
    logic seen = 1'b0;
    logic tmo = (w >= TMO);
    int exp_acc = tmo ? TMO : w + 1;
    logic exp_err = tmo | se;
    logic [DW-1:0] exp_rd = (!wr && !tmo) ? ref_mem[a] : '0;
    slave_wait = w;
    slave_err  = se;
    drive(idx, 1, wr, a, d);
    @(negedge P_clk);
    chk("accept_mine",  32'(idx != 0 ? req1_accept : req0_accept), 1);
    chk("accept_other", 32'(idx != 0 ? req0_accept : req1_accept), 0);
    drive(idx, 0, ~wr, ~a, ~d);
    for (int c = 0; c < 60 && !seen; c++) begin
      if (P_sel && !P_enable) setup_cyc++;
      if (P_sel && P_enable) begin
        if (acc_cyc == 0) begin
          chk("bus_addr",  32'(P_addr), 32'(a));
          chk("bus_write", 32'(P_write), 32'(wr));
          if (wr) chk("bus_wdata", 32'(P_wdata), 32'(d));
        end
        acc_cyc++;
      end
      @(negedge P_clk);
      if (req0_done || req1_done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 1);
    chk("done_mine",  32'(idx != 0 ? req1_done : req0_done), 1);
    chk("done_other", 32'(idx != 0 ? req0_done : req1_done), 0);
    chk("setup_cycles",  32'(setup_cyc), 1);
    chk("access_cycles", 32'(acc_cyc), 32'(exp_acc));
    chk("rsp_rdata", 32'(idx != 0 ? req1_rdata : req0_rdata), 32'(exp_rd));
    chk("rsp_err",   32'(idx != 0 ? req1_err : req0_err), 32'(exp_err));
    chk("idle_psel", 32'(P_sel), 0);
    if (wr && !exp_err) ref_mem[a] = d;
    model_last = (idx != 0);
    @(negedge P_clk);
    chk("done_pulse_width", 32'({req0_done, req1_done}), 0);
    chk("rsp_rdata_held", 32'(idx != 0 ? req1_rdata : req0_rdata), 32'(exp_rd));
    slave_wait = 0;
    slave_err  = 1'b0;
  endtask

  // both requesters hold write requests for n grants; checks round-robin order and idle gap
  task automatic pair(input int n, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int got = 0, dn = 0;
    slave_wait = 0;
    slave_err  = 1'b0;
    drive(0, 1, 1, a0, d0);
    drive(1, 1, 1, a1, d1);
    for (int c = 0; c < 600 && dn < n; c++) begin
      @(negedge P_clk);
      if (req0_done || req1_done) begin
        dn++;
        chk("pair_gap_psel", 32'(P_sel), 0);
        chk("pair_err", 32'(req0_done ? req0_err : req1_err), 0);
        if (req0_done) ref_mem[a0] = d0;
        else           ref_mem[a1] = d1;
      end
      if (req0_accept || req1_accept) begin
        chk("rr_order", 32'(req1_accept), 32'(!model_last));
        chk("single_accept", 32'(req0_accept & req1_accept), 0);
        model_last = req1_accept;
        got++;
        if (got == n) begin
          drive(0, 0, 0, '0, '0);
          drive(1, 0, 0, '0, '0);
        end
      end
    end
    chk("pair_done_count", 32'(dn), 32'(n));
    chk("pair_accept_count", 32'(got), 32'(n));
    @(negedge P_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    apply_reset();

    for (int i = 0; i < 16; i++) xfer(0, 1, 4'(i), 8'(i * 17) ^ 8'h3C, 0, 1'b0);

    xfer(0, 1, 4'h3, 8'hA5, 1, 1'b0);
    xfer(0, 0, 4'h3, 8'h00, 0, 1'b0);
    chk("readback_a5", 32'(req0_rdata), 32'h0000_00A5);

    apply_reset();
    pair(2, 4'h1, 8'h11, 4'h2, 8'h22);
    xfer(1, 0, 4'h1, 8'h00, 2, 1'b0);
    xfer(0, 0, 4'h2, 8'h00, 0, 1'b0);

    pair(6, 4'h5, 8'h5E, 4'h6, 8'h6F);

    xfer(1, 0, 4'h6, 8'h00, 100, 1'b0);
    xfer(1, 0, 4'h6, 8'h00, TMO - 1, 1'b0);
    xfer(0, 1, 4'h8, 8'hC3, TMO, 1'b0);

    xfer(0, 0, 4'h5, 8'h00, 0, 1'b1);
    xfer(0, 0, 4'h5, 8'h00, 0, 1'b0);

    // reset while the slave is stalling in ACCESS
    slave_wait = 100;
    drive(0, 1, 1, 4'h7, 8'h5A);
    @(negedge P_clk);
    chk("mid_accept", 32'(req0_accept), 1);
    drive(0, 0, 0, '0, '0);
    repeat (4) @(negedge P_clk);
    chk("mid_in_access", 32'({P_sel, P_enable}), 32'h3);
    #2 P_reset_n = 1'b0;
    #1 chk_quiet("mid_rst");
    @(negedge P_clk);
    P_reset_n = 1'b1;
    model_last = 1'b1;
    slave_wait = 0;
    @(negedge P_clk);
    pair(2, 4'h9, 8'h99, 4'hA, 8'hAA);
    xfer(1, 0, 4'h7, 8'h00, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int w;
      w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), w,
           1'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
